// File: rtl/rename_free_list_ctrl.sv
// Free-list of physical register IDs for rename: circular FIFO with a sequential INIT fill.
// Optional single branch checkpoint of the head pointer is enabled by RENAME_CHECKPOINT_EN.
module rename_free_list_ctrl #(
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    parameter int PREG_W    = $clog2(PHYS_REGS),
    parameter int DEPTH     = PHYS_REGS - ARCH_REGS,
    parameter int PTR_W     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_alloc_req,
    output logic              o_alloc_valid,
    output logic [PREG_W-1:0] o_alloc_preg,
    input  logic              i_release_valid,
    input  logic [PREG_W-1:0] i_release_preg,
    output logic [PTR_W:0]    o_free_count,
    output logic              o_ready,
    output logic              o_overflow_err
`ifdef RENAME_CHECKPOINT_EN
    ,
    input  logic              i_ckpt_save,
    input  logic              i_ckpt_restore
`endif
);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [PTR_W:0]   PTR_ZERO  = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] FILL_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] FILL_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] FILL_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PREG_W-1:0] PREG_BASE = PREG_W'(ARCH_REGS);
    localparam logic [PREG_W-1:0] PREG_ZERO = {PREG_W{1'b0}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PTR_W:0]    r_head;
    logic [PTR_W:0]    r_tail;
    logic [PTR_W:0]    w_head_nxt;
    logic [PTR_W:0]    w_tail_nxt;
    logic [PTR_W-1:0]  r_fill_idx;
    logic [PTR_W-1:0]  w_fill_idx_nxt;
    logic [PREG_W-1:0] r_fifo [DEPTH];
    logic [PTR_W:0]    r_free_count;
    logic              r_ready;
    logic              r_overflow_err;
    logic              w_overflow_nxt;
    logic              w_empty;
    logic              w_full;
    logic              w_alloc_valid;
    logic              w_grant;
    logic              w_restore;
    logic [PTR_W:0]    w_ckpt_head;
    logic              w_wr_en;
    logic [PTR_W-1:0]  w_wr_idx;
    logic [PREG_W-1:0] w_wr_data;

    assign w_empty = (r_head == r_tail);
    assign w_full  = (r_head[PTR_W-1:0] == r_tail[PTR_W-1:0]) && (r_head[PTR_W] != r_tail[PTR_W]);

`ifdef RENAME_CHECKPOINT_EN
    logic [PTR_W:0] r_snapshot;

    assign w_restore   = i_ckpt_restore && (r_state == ST_READY);
    assign w_ckpt_head = r_snapshot;

    // Snapshot holds the pre-grant head; a same-cycle restore takes priority over save.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_snapshot <= PTR_ZERO;
        end else if ((r_state == ST_READY) && i_ckpt_save && !i_ckpt_restore) begin
            r_snapshot <= r_head;
        end else begin
            r_snapshot <= r_snapshot;
        end
    end
`else
    assign w_restore   = 1'b0;
    assign w_ckpt_head = r_head;
`endif

    assign w_alloc_valid = (r_state == ST_READY) && !w_empty && !w_restore;
    assign w_grant       = i_alloc_req && w_alloc_valid;

    // Next-state, pointer and FIFO write-port decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_head_nxt     = r_head;
        w_tail_nxt     = r_tail;
        w_fill_idx_nxt = r_fill_idx;
        w_overflow_nxt = r_overflow_err;
        w_wr_en        = 1'b0;
        w_wr_idx       = r_tail[PTR_W-1:0];
        w_wr_data      = i_release_preg;
        case (r_state)
            ST_INIT: begin
                w_wr_en        = 1'b1;
                w_wr_idx       = r_fill_idx;
                w_wr_data      = PREG_BASE + PREG_W'(r_fill_idx);
                w_tail_nxt     = r_tail + PTR_ONE;
                w_fill_idx_nxt = r_fill_idx + FILL_ONE;
                if (r_fill_idx == FILL_LAST) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_READY: begin
                if (w_restore) begin
                    w_head_nxt = w_ckpt_head;
                end else if (w_grant) begin
                    w_head_nxt = r_head + PTR_ONE;
                end else begin
                    w_head_nxt = r_head;
                end
                // Preg 0 is the hard-wired zero register and never re-enters the list.
                if (i_release_valid && (i_release_preg != PREG_ZERO)) begin
                    if (w_full) begin
                        w_overflow_nxt = 1'b1;
                    end else begin
                        w_wr_en    = 1'b1;
                        w_tail_nxt = r_tail + PTR_ONE;
                    end
                end else begin
                    w_wr_en = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // State, pointers and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_INIT;
            r_head         <= PTR_ZERO;
            r_tail         <= PTR_ZERO;
            r_fill_idx     <= FILL_ZERO;
            r_overflow_err <= 1'b0;
            r_free_count   <= PTR_ZERO;
            r_ready        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_head         <= w_head_nxt;
            r_tail         <= w_tail_nxt;
            r_fill_idx     <= w_fill_idx_nxt;
            r_overflow_err <= w_overflow_nxt;
            r_free_count   <= w_tail_nxt - w_head_nxt;
            r_ready        <= (w_state_nxt == ST_READY);
        end
    end

    // FIFO storage; contents are fully rewritten by INIT after every reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_fifo[w_wr_idx] <= w_wr_data;
        end
    end

    assign o_alloc_valid  = w_alloc_valid;
    assign o_alloc_preg   = r_fifo[r_head[PTR_W-1:0]];
    assign o_free_count   = r_free_count;
    assign o_ready        = r_ready;
    assign o_overflow_err = r_overflow_err;

endmodule

// File: tb/tb_rename_free_list_ctrl.sv
// Self-checking bench for rename_free_list_ctrl: queue-based free-list model as scoreboard.
// Checkpoint scenarios are compiled in when RENAME_CHECKPOINT_EN is defined.
`timescale 1ns/1ps
module tb_rename_free_list_ctrl;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_preg;
    logic       release_valid;
    logic [5:0] release_preg;
    logic [5:0] free_count;
    logic       ready;
    logic       overflow_err;
    logic       ckpt_save;
    logic       ckpt_restore;

    int         err_cnt = 0;
    int         chk_cnt = 0;
    logic [5:0] model_q [$];
    logic [5:0] since_q [$];
    logic       exp_ovf;
    logic [5:0] last_grant;

    always #5 clk = ~clk;

    rename_free_list_ctrl dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_alloc_req     (alloc_req),
        .o_alloc_valid   (alloc_valid),
        .o_alloc_preg    (alloc_preg),
        .i_release_valid (release_valid),
        .i_release_preg  (release_preg),
        .o_free_count    (free_count),
        .o_ready         (ready),
        .o_overflow_err  (overflow_err)
`ifdef RENAME_CHECKPOINT_EN
        ,
        .i_ckpt_save     (ckpt_save),
        .i_ckpt_restore  (ckpt_restore)
`endif
    );

    // One READY-state cycle: check registered status, drive inputs, check the offer, update the scoreboard.
    task automatic cycle(input logic req, input logic rv, input logic [5:0] rp,
                         input logic sv, input logic rs);
        logic       exp_valid;
        logic       exp_full;
        logic [5:0] exp_preg;
        @(negedge clk);
        chk_cnt++;
        if (free_count !== 6'(model_q.size())) begin
            err_cnt++;
            $display("FAIL free_count: got %0d expected %0d", free_count, model_q.size());
        end
        chk_cnt++;
        if (overflow_err !== exp_ovf) begin
            err_cnt++;
            $display("FAIL overflow_err: got %b expected %b", overflow_err, exp_ovf);
        end
        alloc_req     = req;
        release_valid = rv;
        release_preg  = rp;
        ckpt_save     = sv;
        ckpt_restore  = rs;
        #1;
        exp_valid = (model_q.size() > 0) && !rs;
        exp_full  = (model_q.size() == DEPTH);
        chk_cnt++;
        if (alloc_valid !== exp_valid) begin
            err_cnt++;
            $display("FAIL alloc_valid: got %b expected %b", alloc_valid, exp_valid);
        end
        if (sv && !rs) begin
            since_q.delete();
        end
        if (req && exp_valid) begin
            exp_preg   = model_q.pop_front();
            last_grant = exp_preg;
            since_q.push_back(exp_preg);
            chk_cnt++;
            if (alloc_preg !== exp_preg) begin
                err_cnt++;
                $display("FAIL alloc_preg: got %0d expected %0d", alloc_preg, exp_preg);
            end
        end
        if (rv && (rp != 6'd0)) begin
            if (exp_full) begin
                exp_ovf = 1'b1;
            end else begin
                model_q.push_back(rp);
            end
        end
        if (rs) begin
            for (int i = since_q.size() - 1; i >= 0; i--) begin
                model_q.push_front(since_q[i]);
            end
            since_q.delete();
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    // Reset, check in-reset outputs, optionally restart INIT midway, then time INIT to READY.
    task automatic test_reset(input int restart_after);
        int n;
        @(negedge clk);
        rst = 1'b1; alloc_req = 1'b0; release_valid = 1'b0; release_preg = 6'd0;
        ckpt_save = 1'b0; ckpt_restore = 1'b0;
        @(negedge clk);
        #1;
        chk_cnt++;
        if ({ready, alloc_valid, free_count, overflow_err} !== 9'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got rdy=%b av=%b fc=%0d ovf=%b expected all 0",
                     ready, alloc_valid, free_count, overflow_err);
        end
        rst = 1'b0;
        if (restart_after > 0) begin
            repeat (restart_after) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            #1;
            rst = 1'b0;
        end
        release_valid = 1'b1;
        release_preg  = 6'd9;
        n = 0;
        while ((ready !== 1'b1) && (n < 100)) begin
            chk_cnt++;
            if (alloc_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL init_alloc_valid: got %b expected 0 at init cycle %0d", alloc_valid, n);
            end
            @(negedge clk);
            #1;
            n++;
        end
        release_valid = 1'b0;
        release_preg  = 6'd0;
        chk_cnt++;
        if (n !== 32) begin
            err_cnt++;
            $display("FAIL init_length: got %0d cycles expected 32", n);
        end
        chk_cnt++;
        if ((free_count !== 6'd32) || (alloc_preg !== 6'd32)) begin
            err_cnt++;
            $display("FAIL init_done: got fc=%0d preg=%0d expected fc=32 preg=32", free_count, alloc_preg);
        end
        model_q.delete();
        since_q.delete();
        for (int i = 32; i < 64; i++) begin
            model_q.push_back(6'(i));
        end
        exp_ovf = 1'b0;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        idle();
        chk_cnt++;
        if ((free_count !== 6'd0) || (alloc_valid !== 1'b0) || (last_grant !== 6'd63)) begin
            err_cnt++;
            $display("FAIL drain_end: got fc=%0d av=%b last=%0d expected 0 0 63",
                     free_count, alloc_valid, last_grant);
        end
    endtask

    task automatic test_refill_wrap();
        logic [5:0] refill [4];
        refill[0] = 6'd40; refill[1] = 6'd7; refill[2] = 6'd0; refill[3] = 6'd33;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, refill[i], 1'b0, 1'b0);
        end
        idle();
        chk_cnt++;
        if (free_count !== 6'd3) begin
            err_cnt++;
            $display("FAIL refill_count: got %0d expected 3", free_count);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 6'($urandom_range(1, 63)), 1'b0, 1'b0);
        end
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b1, 6'($urandom_range(1, 63)), 1'b0, 1'b0);
        end
        idle();
        chk_cnt++;
        if (free_count !== 6'd5) begin
            err_cnt++;
            $display("FAIL pair_count: got %0d expected 5", free_count);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        end
        idle();
    endtask

    task automatic test_overflow();
        test_reset(0);
        cycle(1'b0, 1'b1, 6'd5, 1'b0, 1'b0);
        idle();
        chk_cnt++;
        if ((overflow_err !== 1'b1) || (free_count !== 6'd32)) begin
            err_cnt++;
            $display("FAIL overflow: got ovf=%b fc=%0d expected 1 32", overflow_err, free_count);
        end
        cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        idle();
        test_reset(0);
        idle();
    endtask

`ifdef RENAME_CHECKPOINT_EN
    task automatic test_checkpoint();
        test_reset(0);
        cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
        idle();
        chk_cnt++;
        if ((free_count !== 6'd30) || (alloc_preg !== 6'd34)) begin
            err_cnt++;
            $display("FAIL ckpt_restore: got fc=%0d preg=%0d expected 30 34", free_count, alloc_preg);
        end
        cycle(1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 6'd0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
        idle();
    endtask

    task automatic test_ckpt_corner();
        test_reset(0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        end
        cycle(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 6'd9, 1'b0, 1'b1);
        idle();
        chk_cnt++;
        if ((free_count !== 6'd30) || (alloc_preg !== 6'd35)) begin
            err_cnt++;
            $display("FAIL ckpt_corner: got fc=%0d preg=%0d expected 30 35", free_count, alloc_preg);
        end
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        end
        idle();
        chk_cnt++;
        if (last_grant !== 6'd9) begin
            err_cnt++;
            $display("FAIL ckpt_corner_tail: got %0d expected 9", last_grant);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; alloc_req = 1'b0; release_valid = 1'b0; release_preg = 6'd0;
        ckpt_save = 1'b0; ckpt_restore = 1'b0; exp_ovf = 1'b0; last_grant = 6'd0;
        test_reset(0);
        test_reset(10);
        test_drain();
        test_refill_wrap();
        test_overflow();
`ifdef RENAME_CHECKPOINT_EN
        test_checkpoint();
        test_ckpt_corner();
`endif
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
